// File: rtl/mux_sel_arbiter.sv
// rtl/mux_sel_arbiter.sv - round-robin burst arbiter driving a 4:1 bus mux select, with registered output
//
// Ports:
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   req[3:0]    in   per-channel word available, held until acknowledged
//   ack[3:0]    out  one-hot, high in the cycle the granted channel's word is captured
//   sel[1:0]    out  registered mux select (granted channel index)
//   mux_out     in   mux output, the word of channel sel
//   data_out    out  registered output word
//   data_valid  out  data_out holds an unconsumed word
//   data_ready  in   downstream accepts data_out when data_valid && data_ready
//   busy        out  high while a grant is held
//
// Optional build macro: ARB_CH0_PRIO_EN gives channel 0 priority over the
// round-robin pointer and lets it cut short a burst on channels 1-3.

module mux_sel_arbiter #(
    parameter int BUS_WIDTH = 16,
    parameter int BURST_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           req,
    output logic [3:0]           ack,
    output logic [1:0]           sel,
    input  logic [BUS_WIDTH-1:0] mux_out,
    output logic [BUS_WIDTH-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(BURST_MAX - 1);

    state_t     state, state_nx;
    logic [1:0] sel_nx;
    logic [1:0] last, last_nx;
    logic [3:0] cnt, cnt_nx;
    logic [1:0] pick;
    logic       xfer;
    logic       release_grant;
    logic       prio_release;

    // First requester after the last-served channel; k=4 wraps back to last itself.
    always_comb begin
        logic [1:0] cand;
        logic       found;
        pick  = last + 2'd1;
        found = 1'b0;
        cand  = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
`ifdef ARB_CH0_PRIO_EN
        if (req[0]) begin
            pick = 2'd0;
        end
`endif
    end

    // A word moves only when the output register is empty or being drained this cycle.
    assign xfer = (state == GRANT) && req[sel] && (!data_valid || data_ready);
    assign ack  = xfer ? (4'b0001 << sel) : 4'b0000;
    assign busy = (state == GRANT);

`ifdef ARB_CH0_PRIO_EN
    // Once a lower channel has moved at least one word, a channel 0 request ends
    // the burst after this cycle whether or not a transfer happens in it.
    assign prio_release = (sel != 2'd0) && (cnt != 4'd0) && req[0];
`else
    assign prio_release = 1'b0;
`endif

    assign release_grant = !req[sel] || (xfer && (cnt == LAST_CNT)) || prio_release;

    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        last_nx  = last;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_nx = GRANT;
                    sel_nx   = pick;
                    cnt_nx   = 4'd0;
                end
            end
            GRANT: begin
                if (xfer) begin
                    cnt_nx = cnt + 4'd1;
                end
                if (release_grant) begin
                    state_nx = IDLE;
                    last_nx  = sel;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= 2'd0;
            last  <= 2'd3;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            sel   <= sel_nx;
            last  <= last_nx;
            cnt   <= cnt_nx;
        end
    end

    // Push wins over pop, so a simultaneous drain and capture keeps data_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else if (xfer) begin
            data_out   <= mux_out;
            data_valid <= 1'b1;
        end else if (data_ready) begin
            data_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb/tb_mux_sel_arbiter.sv - self-checking bench for mux_sel_arbiter

module tb_mux_sel_arbiter;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req;
    logic [3:0]   ack;
    logic [1:0]   sel;
    logic [W-1:0] mux_out;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         data_ready = 1'b0;
    logic         busy;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] src_cnt [4] = '{default: '0};
    int           src_left[4] = '{default: 0};
    int           exp_cnt [4] = '{default: 0};
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [W-1:0] base(input int i);
        return W'((i + 1) * 'h1000);
    endfunction

    always_comb mux_out = base(int'(sel)) + src_cnt[sel];

    always_comb begin
        req = 4'b0000;
        for (int i = 0; i < 4; i++) req[i] = (src_left[i] != 0);
    end

    mux_sel_arbiter #(.BUS_WIDTH(W), .BURST_MAX(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .ack        (ack),
        .sel        (sel),
        .mux_out    (mux_out),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy)
    );

    // Scoreboard drain and ack legality, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            tests++;
            if (ack !== 4'b0000 && (ack !== (4'b0001 << sel) || !busy)) begin
                fails++;
                $display("FAIL ack_onehot: ack=%b sel=%0d busy=%b", ack, sel, busy);
            end
            if (data_valid && data_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected: got %h, expected nothing", data_out);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    if (data_out !== e) begin
                        fails++;
                        $display("FAIL sb_data: got %h, expected %h", data_out, e);
                    end
                end
            end
        end
    end

    task automatic push(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(base(ch) + W'(exp_cnt[ch]));
            exp_cnt[ch]++;
        end
    endtask

    // One clock; the sources advance on words the DUT acknowledged.
    task automatic step();
        logic [3:0] a;
        @(negedge clk);
        a = ack;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (a[i]) begin
                src_cnt[i]  = src_cnt[i] + 1'b1;
                src_left[i] = src_left[i] - 1;
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        data_ready = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && !busy && !data_valid && req == 4'b0000) && n < budget) begin
            step();
            n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL wait_idle_timeout: queue=%0d busy=%b valid=%b req=%b", exp_q.size(), busy, data_valid, req);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests += 5;
        if (sel !== 2'd0)        begin fails++; $display("FAIL reset_sel: got %0d, expected 0", sel); end
        if (data_out !== '0)     begin fails++; $display("FAIL reset_data_out: got %h, expected 0", data_out); end
        if (data_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, expected 0", data_valid); end
        if (ack !== 4'b0000)     begin fails++; $display("FAIL reset_ack: got %b, expected 0000", ack); end
        if (busy !== 1'b0)       begin fails++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    endtask

    task automatic test_single_channel();
        apply_reset();
        push(0, 8);
        src_left[0] = 8;
        step();
        tests += 3;
        if (sel !== 2'd0)     begin fails++; $display("FAIL single_sel_c1: got %0d, expected 0", sel); end
        if (busy !== 1'b1)    begin fails++; $display("FAIL single_busy_c1: got %b, expected 1", busy); end
        if (ack !== 4'b0001)  begin fails++; $display("FAIL single_ack_c1: got %b, expected 0001", ack); end
        step();
        tests += 2;
        if (data_out !== 16'h1000) begin fails++; $display("FAIL single_data_c2: got %h, expected 1000", data_out); end
        if (data_valid !== 1'b1)   begin fails++; $display("FAIL single_valid_c2: got %b, expected 1", data_valid); end
        repeat (3) step();
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL single_bubble_c5: busy=%b, expected 0", busy); end
        step();
        tests += 2;
        if (busy !== 1'b1) begin fails++; $display("FAIL single_regrant_c6: busy=%b, expected 1", busy); end
        if (sel !== 2'd0)  begin fails++; $display("FAIL single_regrant_sel: got %0d, expected 0", sel); end
        wait_idle(100);
    endtask

    task automatic test_all_channels();
        int idle_cyc, busy_cyc, n0, total, exp_idle;
`ifdef ARB_CH0_PRIO_EN
        n0 = 4;
`else
        n0 = 8;
`endif
        total    = (n0 / 4 + 3) * 5;
        exp_idle = n0 / 4 + 3;
        apply_reset();
        push(0, 4); push(1, 4); push(2, 4); push(3, 4);
        if (n0 == 8) push(0, 4);
        src_left[0] = n0;
        src_left[1] = 4; src_left[2] = 4; src_left[3] = 4;
        idle_cyc = 0;
        busy_cyc = 0;
        for (int c = 0; c < total; c++) begin
            if (busy) busy_cyc++; else idle_cyc++;
            step();
        end
        tests += 2;
        if (idle_cyc !== exp_idle) begin fails++; $display("FAIL all_bubbles: got %0d, expected %0d", idle_cyc, exp_idle); end
        if (busy_cyc !== total - exp_idle) begin fails++; $display("FAIL all_grant_cycles: got %0d, expected %0d", busy_cyc, total - exp_idle); end
        wait_idle(100);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] first;
        apply_reset();
        first = base(2) + W'(exp_cnt[2]);
        push(2, 4);
        src_left[2] = 4;
        step();
        tests++;
        if (ack !== 4'b0100) begin fails++; $display("FAIL bp_first_ack: got %b, expected 0100", ack); end
        data_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            tests += 3;
            if (data_out !== first) begin fails++; $display("FAIL bp_hold_data: got %h, expected %h", data_out, first); end
            if (ack !== 4'b0000)    begin fails++; $display("FAIL bp_no_ack: got %b, expected 0000", ack); end
            if (sel !== 2'd2)       begin fails++; $display("FAIL bp_sel_stable: got %0d, expected 2", sel); end
        end
        data_ready = 1'b1;
        #1;
        tests++;
        if (ack !== 4'b0100) begin fails++; $display("FAIL bp_resume_ack: got %b, expected 0100", ack); end
        wait_idle(100);
    endtask

    task automatic test_req_drop();
        apply_reset();
        push(1, 2); push(3, 4);
        src_left[1] = 2;
        src_left[3] = 4;
        repeat (5) step();
        tests += 2;
        if (busy !== 1'b1) begin fails++; $display("FAIL drop_next_busy: got %b, expected 1", busy); end
        if (sel !== 2'd3)  begin fails++; $display("FAIL drop_next_sel: got %0d, expected 3", sel); end
        wait_idle(100);
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        data_ready = 1'b0;
        src_left[3] = 8;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        tests += 5;
        if (sel !== 2'd0)        begin fails++; $display("FAIL midrst_sel: got %0d, expected 0", sel); end
        if (data_out !== '0)     begin fails++; $display("FAIL midrst_data_out: got %h, expected 0", data_out); end
        if (data_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b, expected 0", data_valid); end
        if (ack !== 4'b0000)     begin fails++; $display("FAIL midrst_ack: got %b, expected 0000", ack); end
        if (busy !== 1'b0)       begin fails++; $display("FAIL midrst_busy: got %b, expected 0", busy); end
        exp_cnt[3] = exp_cnt[3] + (8 - src_left[3]);
        rst_n = 1'b1;
        data_ready = 1'b1;
        push(3, src_left[3]);
        #1;
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL midrst_fresh_idle: busy=%b, expected 0", busy); end
        step();
        tests += 2;
        if (busy !== 1'b1) begin fails++; $display("FAIL midrst_regrant_busy: got %b, expected 1", busy); end
        if (sel !== 2'd3)  begin fails++; $display("FAIL midrst_regrant_sel: got %0d, expected 3", sel); end
        wait_idle(100);
    endtask

`ifdef ARB_CH0_PRIO_EN
    task automatic test_ch0_priority();
        apply_reset();
        push(3, 2); push(0, 4); push(1, 4); push(2, 4); push(3, 2);
        src_left[3] = 4;
        step();
        step();
        src_left[0] = 4; src_left[1] = 4; src_left[2] = 4;
        step();
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL prio_bubble: busy=%b, expected 0", busy); end
        step();
        tests += 2;
        if (busy !== 1'b1) begin fails++; $display("FAIL prio_grant_busy: got %b, expected 1", busy); end
        if (sel !== 2'd0)  begin fails++; $display("FAIL prio_grant_sel: got %0d, expected 0", sel); end
        wait_idle(150);
    endtask
`endif

    initial begin
        test_reset();
        test_single_channel();
        test_all_channels();
        test_backpressure();
        test_req_drop();
        test_reset_mid_burst();
`ifdef ARB_CH0_PRIO_EN
        test_ch0_priority();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
